// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction fetch front end.
package fetch_pkg;

  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous instruction buffer of fetch_entry_t; flush empties it in one cycle.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int           DEPTH       = 4,
  parameter fetch_entry_t RESET_ENTRY = '0
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push,
  input  fetch_entry_t           wdata,
  input  logic                   pop,
  input  logic                   flush,
  output fetch_entry_t           rdata,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t  mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;

  // Storage, pointers and occupancy.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= RESET_ENTRY;
      end
    end else if (flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push) begin
        mem_r[wr_ptr_r] <= wdata;
        wr_ptr_r        <= wr_ptr_r + AW'(1'b1);
      end
      if (pop) begin
        rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      end
      count_r <= count_r + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  assign rdata   = mem_r[rd_ptr_r];
  assign count_o = count_r;
  assign full_o  = (count_r == (AW+1)'(DEPTH));
  assign empty_o = (count_r == '0);

endmodule

// File: rtl/fetch_unit_checker.sv
// Simulation-only protocol checks for fetch_unit.
module fetch_unit_checker #(
  parameter int CW = 3
) (
  input logic          clk_i,
  input logic          rst_ni,
  input logic          imem_rvalid_i,
  input logic [CW-1:0] outstanding,
  input logic          push,
  input logic          full
);

  // Responses must match an outstanding read; the credit rule keeps the buffer from overflowing.
  always @(posedge clk_i) begin
    if (rst_ni) begin
      assert (!(imem_rvalid_i && (outstanding == '0)))
        else $error("imem_rvalid_i with no read outstanding");
      assert (!(push && full))
        else $error("push into a full instruction buffer");
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC generation, credit-limited reads, stale-response discard
// and a decode-facing buffer. FETCH_BYPASS_EN forwards responses to decode when the buffer is empty.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o
);

  localparam int           CW          = $clog2(FIFO_DEPTH) + 1;
  localparam logic [31:0]  BOOT_PC     = {RESET_PC[31:2], 2'b00};
  localparam logic [CW:0]  DEPTH_LIMIT = (CW+1)'(FIFO_DEPTH);
  localparam fetch_entry_t RESET_ENTRY = '{inst: NOP_INST, pc: BOOT_PC};

  logic [31:0]   fpc_r;
  logic [31:0]   rsp_pc_r;
  logic [CW-1:0] outstanding_r;
  logic [CW-1:0] discard_r;

  logic [CW-1:0] fifo_count_s;
  logic          fifo_full_s;
  logic          fifo_empty_s;
  fetch_entry_t  head_s;
  fetch_entry_t  push_entry_s;
  logic [31:0]   redirect_pc_s;
  logic          credit_s;
  logic          req_s;
  logic          grant_s;
  logic          resp_s;
  logic          accept_s;
  logic          push_s;
  logic          pop_s;

  assign redirect_pc_s = word_align(redirect_pc_i);

  // Buffered plus in-flight words may never exceed the buffer; held low while in reset.
  assign credit_s = ({1'b0, fifo_count_s} + {1'b0, outstanding_r}) < DEPTH_LIMIT;
  assign req_s    = rst_ni && !redirect_i && credit_s;
  assign grant_s  = req_s && imem_gnt_i;
  assign resp_s   = imem_rvalid_i && (outstanding_r != '0);
  assign accept_s = resp_s && !redirect_i && (discard_r == '0);

  assign imem_req_o  = req_s;
  assign imem_addr_o = fpc_r;

  // Fetch PC, response PC, in-flight and discard counters.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      fpc_r         <= BOOT_PC;
      rsp_pc_r      <= BOOT_PC;
      outstanding_r <= '0;
      discard_r     <= '0;
    end else begin
      outstanding_r <= outstanding_r + CW'(grant_s) - CW'(resp_s);
      if (redirect_i) begin
        fpc_r     <= redirect_pc_s;
        rsp_pc_r  <= redirect_pc_s;
        discard_r <= outstanding_r - CW'(resp_s);
      end else begin
        if (grant_s) begin
          fpc_r <= fpc_r + 32'd4;
        end
        if (accept_s) begin
          rsp_pc_r <= rsp_pc_r + 32'd4;
        end
        if (resp_s && (discard_r != '0)) begin
          discard_r <= discard_r - CW'(1'b1);
        end
      end
    end
  end

  assign push_entry_s = '{inst: imem_rdata_i, pc: rsp_pc_r};
  assign pop_s        = inst_valid_o && inst_ready_i && !redirect_i && !fifo_empty_s;

`ifdef FETCH_BYPASS_EN
  assign push_s = accept_s && !(fifo_empty_s && inst_ready_i);

  // Empty buffer: the accepted response goes straight to decode.
  always_comb begin
    inst_valid_o = !fifo_empty_s;
    inst_o       = head_s.inst;
    inst_pc_o    = head_s.pc;
    if (fifo_empty_s && accept_s) begin
      inst_valid_o = 1'b1;
      inst_o       = imem_rdata_i;
      inst_pc_o    = rsp_pc_r;
    end else begin
      inst_valid_o = !fifo_empty_s;
    end
  end
`else
  assign push_s = accept_s;

  // Decode sees only the registered buffer head.
  always_comb begin
    inst_valid_o = !fifo_empty_s;
    inst_o       = head_s.inst;
    inst_pc_o    = head_s.pc;
  end
`endif

  fetch_fifo #(
    .DEPTH       (FIFO_DEPTH),
    .RESET_ENTRY (RESET_ENTRY)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push    (push_s),
    .wdata   (push_entry_s),
    .pop     (pop_s),
    .flush   (redirect_i),
    .rdata   (head_s),
    .count_o (fifo_count_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s)
  );

  fetch_unit_checker #(
    .CW (CW)
  ) u_checker (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .imem_rvalid_i (imem_rvalid_i),
    .outstanding   (outstanding_r),
    .push          (push_s),
    .full          (fifo_full_s)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit against a queue-based memory and instruction-stream model.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam logic [31:0] RPC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n, gnt, rvalid, redirect, ready, req, valid;
  logic [31:0] rdata, redirect_pc, addr, inst, inst_pc;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RPC), .FIFO_DEPTH(4)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .imem_req_o(req), .imem_addr_o(addr), .imem_gnt_i(gnt),
    .imem_rvalid_i(rvalid), .imem_rdata_i(rdata),
    .redirect_i(redirect), .redirect_pc_i(redirect_pc),
    .inst_valid_o(valid), .inst_ready_i(ready),
    .inst_o(inst), .inst_pc_o(inst_pc)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          stale;
  } rd_t;

  rd_t         pend[$];
  int          cyc, lat, buffered, delivered, dropped, vectors, errors;
  logic [31:0] exp_fpc, exp_out_pc, saved;
  bit          gnt_en, ready_en, redir_en, rst_en;
  logic [31:0] redir_target;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: drive memory/decode inputs, check outputs at negedge, advance the model.
  task automatic step();
    bit  ret;
    rd_t head;
    ret         = !rst_en && (pend.size() > 0) && (pend[0].due <= cyc);
    rst_n       = !rst_en;
    rvalid      = ret;
    rdata       = ret ? mem_word(pend[0].addr) : 32'hDEAD_BEEF;
    gnt         = gnt_en;
    ready       = ready_en;
    redirect    = redir_en && !rst_en;
    redirect_pc = redir_target;
    @(negedge clk);
    if (rst_en) begin
      check_eq("req_in_reset", req, 32'd0);
    end else begin
      check_eq("req_credit", req, (!redirect && (pend.size() + buffered < 4)));
      if (req) check_eq("fetch_addr", addr, exp_fpc);
      check_eq("inst_valid", valid, (buffered > 0));
      if (valid && ready && !redirect) begin
        check_eq("inst_pc", inst_pc, exp_out_pc);
        check_eq("inst_word", inst, mem_word(exp_out_pc));
        exp_out_pc += 32'd4;
        buffered--;
        delivered++;
      end
    end
    if (rst_en) begin
      pend.delete();
      buffered   = 0;
      exp_fpc    = RPC;
      exp_out_pc = RPC;
    end else begin
      if (ret) begin
        head = pend.pop_front();
        if (head.stale || redirect) dropped++;
        else buffered++;
      end
      if (req && gnt) begin
        pend.push_back('{addr: addr, due: cyc + lat, stale: 1'b0});
        exp_fpc += 32'd4;
      end
      if (redirect) begin
        foreach (pend[i]) pend[i].stale = 1'b1;
        buffered   = 0;
        exp_fpc    = {redirect_pc[31:2], 2'b00};
        exp_out_pc = exp_fpc;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    int n, d0, x0;
    cyc = 0; lat = 1; buffered = 0; delivered = 0; dropped = 0; vectors = 0; errors = 0;
    exp_fpc = RPC; exp_out_pc = RPC;
    gnt_en = 1'b0; ready_en = 1'b1; redir_en = 1'b0; redir_target = 32'd0; rst_en = 1'b1;

    // Reset boot
    repeat (3) step();
    check_eq("rst_valid", valid, 32'd0);
    check_eq("rst_inst", inst, NOP_INST);
    check_eq("rst_pc", inst_pc, RPC);
    rst_en = 1'b0; gnt_en = 1'b1;
    repeat (10) step();
    d0 = delivered;
    repeat (20) step();
    check_eq("boot_throughput", delivered - d0, 32'd20);

    // Back-pressure
    ready_en = 1'b0;
    repeat (10) step();
    check_eq("bp_req_dropped", req, 32'd0);
    ready_en = 1'b1;
    d0 = delivered;
    repeat (4) step();
    check_eq("bp_drain", delivered - d0, 32'd4);

    // Redirect with 3 outstanding, latency 3
    lat = 3; n = 0;
    while (pend.size() != 3 && n < 50) begin step(); n++; end
    check_eq("wait_three_outstanding", pend.size(), 32'd3);
    x0 = dropped;
    redir_en = 1'b1; redir_target = 32'h2000;
    step();
    redir_en = 1'b0;
    check_eq("redir_next_addr", addr, 32'h2000);
    repeat (15) step();
    check_eq("redir_stale_dropped", dropped - x0, 32'd3);

    // Redirect together with rvalid and a ready decode
    lat = 1; n = 0;
    repeat (6) step();
    while (!((pend.size() > 0) && (pend[0].due <= cyc) && (buffered > 0)) && n < 50) begin
      step(); n++;
    end
    check_eq("wait_rvalid_buffered", (pend.size() > 0) && (pend[0].due <= cyc) && (buffered > 0), 32'd1);
    redir_en = 1'b1; redir_target = 32'h3003;
    step();
    redir_en = 1'b0;
    check_eq("coinc_valid_after", valid, 32'd0);
    check_eq("coinc_next_addr", addr, 32'h3000);
    repeat (8) step();

    // Grant stall
    gnt_en = 1'b0;
    saved = addr;
    repeat (5) begin
      step();
      check_eq("stall_addr", addr, saved);
    end
    gnt_en = 1'b1;
    repeat (8) step();

    // Mid-stream reset with 2 reads outstanding
    lat = 3; n = 0;
    while (pend.size() != 2 && n < 50) begin step(); n++; end
    check_eq("wait_two_outstanding", pend.size(), 32'd2);
    rst_en = 1'b1;
    step();
    rst_en = 1'b0;
    check_eq("mrst_valid", valid, 32'd0);
    check_eq("mrst_inst", inst, NOP_INST);
    check_eq("mrst_pc", inst_pc, RPC);
    check_eq("mrst_addr", addr, RPC);
    repeat (20) step();

    // Random traffic
    d0 = delivered;
    for (int i = 0; i < 1500; i++) begin
      if (i % 100 == 0) lat = $urandom_range(1, 4);
      gnt_en       = ($urandom % 4) != 0;
      ready_en     = ($urandom % 3) != 0;
      redir_en     = ($urandom % 40) == 0;
      redir_target = $urandom;
      step();
    end
    redir_en = 1'b0;
    check_eq("random_progress", (delivered - d0) > 200, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
